int_coalescer: RTL and testbench
================================

Name: int_coalescer

Overview:
- Per-channel interrupt event coalescer, directly upstream of the PCIe interrupt router.
- Turns single-cycle event pulses from DMA/user blocks into level int_valid requests.
- A request is held until the router acks it with a one-cycle int_ready pulse.
- Events are batched until a per-channel count threshold or holdoff timeout is reached, which cuts the MSI/legacy interrupt rate.

Parameters:
- COUNT, 16, number of channels (1..32); matches router COUNT.
- CNT_W, 8, width of per-channel event counter and threshold.
- TMR_W, 16, width of per-channel holdoff timer and timeout (clk cycles).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write strobe
- cfg_ready  out  1  constant 1
- cfg_chan  in  5  channel to configure
- cfg_thresh  in  CNT_W  event count threshold
- cfg_timeout  in  TMR_W  holdoff timeout; 0 = no timeout
- ev_pulse  in  COUNT  per-channel event, one event per high cycle
- int_valid  out  COUNT  per-channel interrupt request, to router int_valid
- int_ready  in  COUNT  per-channel ack pulse, from router int_ready
- stat_sel  in  5  channel selector for status readout
- stat_count  out  CNT_W  events in the last acked batch of channel stat_sel
- ovf  out  COUNT  sticky: event lost because counter was saturated
- ovf_clr  in  COUNT  clear the matching ovf bits

Behaviour:
- Reset values:
  - int_valid=0, ovf=0, stat_count=0, all counters/timers/last_count=0.
  - All states IDLE, thresh[i]=1, timeout[i]=0.
- Reset mid-operation: all outputs reach reset values at the next edge; in-flight batches are discarded.
- Config:
  - On cfg_valid: thresh[cfg_chan]<=cfg_thresh and timeout[cfg_chan]<=cfg_timeout. New values are used from the next cycle, including by a channel already in ACCUM.
  - cfg_chan>=COUNT is ignored.
  - thresh=0 is treated as 1.
- Per-channel FSM, states IDLE / ACCUM / FIRE; int_valid[i]=1 only in FIRE.
- IDLE:
  - ev_pulse -> count<=1, timer<=0, go to ACCUM.
- ACCUM:
  - Every cycle: timer<=timer+1, saturating at all-ones.
  - ev -> count<=count+1, saturating at all-ones.
  - Go to FIRE when (count+ev)>=thresh, or when timeout!=0 and timer+1>=timeout; both compared unsigned in CNT_W+1 / TMR_W+1 bits.
  - Latency with thresh=1: event at edge N -> ACCUM at N+1 -> int_valid high after edge N+2.
- FIRE:
  - Events keep accumulating into the same batch (saturating); timer is frozen.
  - int_ready[i] while in FIRE: last_count[i]<=count+ev (saturating), timer<=0.
    - If ev in the same cycle: count<=1, go to ACCUM.
    - Otherwise count<=0, go to IDLE.
  - Result: int_valid is low for at least one cycle after every ack.
  - int_ready[i] outside FIRE is ignored.
- Saturation:
  - Any ev arriving while count is all-ones (ACCUM or FIRE) sets ovf[i].
  - ovf_clr[i] clears ovf[i]; if set and clear coincide, set wins.
- Status:
  - stat_count<=last_count[stat_sel] every cycle (1-cycle latency).
  - stat_sel>=COUNT -> 0.
  - last_count holds its value until the next ack of that channel.
- Channels are fully independent; all COUNT channels may fire and be acked in the same cycle.
- Implementation scope: 120–400 lines of RTL.

Test Plan:
- Reset defaults (thresh=1, timeout=0): pulse ev_pulse[3] at cycle 10 -> int_valid[3] rises at cycle 12. Ack int_ready[3] at cycle 15 -> int_valid[3]=0 at 16; stat_sel=3 gives stat_count=1.
- Threshold: cfg ch0 thresh=4, timeout=0; send 3 events -> int_valid[0] stays 0 indefinitely. 4th event -> int_valid[0]=1 next cycle. Ack -> stat_count=4.
- Timeout: cfg ch1 thresh=100, timeout=20; one event at cycle 0 -> int_valid[1] rises at cycle 21. 5 more events while in FIRE, then ack -> stat_count=6.
- Ack coincident with event: ch2 in FIRE, ev_pulse[2] and int_ready[2] in the same cycle -> int_valid[2] low for exactly 1 cycle, then high again (thresh=1); the next batch count is 1.
- Saturation: CNT_W=8, ch4 thresh=255, 300 events -> int_valid[4]=1 and ovf[4]=1; ack gives stat_count=255. ovf_clr[4] -> ovf[4]=0.
- Reset mid-batch: ch5 in ACCUM with count=7, assert reset for 1 cycle -> int_valid=0, thresh[5] back to 1; a new event fires after 2 cycles.

Source files
------------

// File: rtl/int_coalescer.sv
// Per-channel interrupt coalescer: batches event pulses into level int_valid requests for the router.
// Latency: with thresh=1 an event raises int_valid two edges later; stat_count lags last_count by one cycle.
// Backpressure: a request holds in FIRE until int_ready; events keep counting (saturating) while it waits.
module int_coalescer #(
   parameter int COUNT = 16,
   parameter int CNT_W = 8,
   parameter int TMR_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [4:0]       cfg_chan,
   input  logic [CNT_W-1:0] cfg_thresh,
   input  logic [TMR_W-1:0] cfg_timeout,
   input  logic [COUNT-1:0] ev_pulse,
   output logic [COUNT-1:0] int_valid,
   input  logic [COUNT-1:0] int_ready,
   input  logic [4:0]       stat_sel,
   output logic [CNT_W-1:0] stat_count,
   output logic [COUNT-1:0] ovf,
   input  logic [COUNT-1:0] ovf_clr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FIRE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q   [COUNT];
   state_t           state_d   [COUNT];
   logic [CNT_W-1:0] count_q   [COUNT];
   logic [CNT_W-1:0] count_d   [COUNT];
   logic [TMR_W-1:0] timer_q   [COUNT];
   logic [TMR_W-1:0] timer_d   [COUNT];
   logic [CNT_W-1:0] last_q    [COUNT];
   logic [CNT_W-1:0] last_d    [COUNT];
   logic [CNT_W-1:0] thresh_q  [COUNT];
   logic [TMR_W-1:0] timeout_q [COUNT];

   // Per-channel arithmetic, widened by one bit so compares see the true sum
   logic [CNT_W:0]   ev_sum    [COUNT];
   logic [CNT_W-1:0] cnt_inc   [COUNT];
   logic [CNT_W-1:0] thr_eff   [COUNT];
   logic [TMR_W:0]   tmr_sum   [COUNT];
   logic [TMR_W-1:0] tmr_inc   [COUNT];
   logic [COUNT-1:0] thr_hit;
   logic [COUNT-1:0] tmo_hit;
   logic [COUNT-1:0] ev_lost;
   logic [COUNT-1:0] ovf_d;
   logic [CNT_W-1:0] stat_d;

   assign cfg_ready = 1'b1;

   for (genvar g = 0; g < COUNT; g++) begin : g_chan
      assign ev_sum[g]    = {1'b0, count_q[g]} + {{CNT_W{1'b0}}, ev_pulse[g]};
      assign cnt_inc[g]   = ev_sum[g][CNT_W] ? CNT_MAX : ev_sum[g][CNT_W-1:0];
      // A zero threshold would fire on an empty batch; treat it as one event
      assign thr_eff[g]   = (thresh_q[g] == '0) ? CNT_ONE : thresh_q[g];
      assign thr_hit[g]   = (ev_sum[g] >= {1'b0, thr_eff[g]});
      assign tmr_sum[g]   = {1'b0, timer_q[g]} + {{TMR_W{1'b0}}, 1'b1};
      assign tmr_inc[g]   = tmr_sum[g][TMR_W] ? TMR_MAX : tmr_sum[g][TMR_W-1:0];
      assign tmo_hit[g]   = (timeout_q[g] != '0) && (tmr_sum[g] >= {1'b0, timeout_q[g]});
      assign ev_lost[g]   = ev_pulse[g] && (count_q[g] == CNT_MAX) && (state_q[g] != IDLE);
      assign int_valid[g] = (state_q[g] == FIRE);
   end

   // Configuration registers; out-of-range channel numbers match no channel
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < COUNT; i++) begin
            thresh_q[i]  <= CNT_ONE;
            timeout_q[i] <= '0;
         end
      end else if (cfg_valid) begin
         for (int i = 0; i < COUNT; i++) begin
            if (cfg_chan == 5'(i)) begin
               thresh_q[i]  <= cfg_thresh;
               timeout_q[i] <= cfg_timeout;
            end
         end
      end
   end

   // Per-channel next state: batch accumulation, fire decision and ack handling
   always_comb begin
      ovf_d = (ovf & ~ovf_clr) | ev_lost;
      for (int i = 0; i < COUNT; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         timer_d[i] = timer_q[i];
         last_d[i]  = last_q[i];
         case (state_q[i])
            IDLE: begin
               if (ev_pulse[i]) begin
                  count_d[i] = CNT_ONE;
                  timer_d[i] = '0;
                  state_d[i] = ACCUM;
               end
            end
            ACCUM: begin
               timer_d[i] = tmr_inc[i];
               count_d[i] = cnt_inc[i];
               if (thr_hit[i] || tmo_hit[i]) begin
                  state_d[i] = FIRE;
               end
            end
            FIRE: begin
               if (int_ready[i]) begin
                  last_d[i]  = cnt_inc[i];
                  timer_d[i] = '0;
                  // An event in the ack cycle opens the next batch immediately
                  if (ev_pulse[i]) begin
                     count_d[i] = CNT_ONE;
                     state_d[i] = ACCUM;
                  end else begin
                     count_d[i] = '0;
                     state_d[i] = IDLE;
                  end
               end else begin
                  count_d[i] = cnt_inc[i];
               end
            end
            default: begin
               state_d[i] = IDLE;
               count_d[i] = '0;
               timer_d[i] = '0;
            end
         endcase
      end
   end

   // Status mux; unknown channels read as zero
   always_comb begin
      stat_d = '0;
      for (int i = 0; i < COUNT; i++) begin
         if (stat_sel == 5'(i)) begin
            stat_d = last_q[i];
         end
      end
   end

   // State register for all channels, status and sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < COUNT; i++) begin
            state_q[i] <= IDLE;
            count_q[i] <= '0;
            timer_q[i] <= '0;
            last_q[i]  <= '0;
         end
         ovf        <= '0;
         stat_count <= '0;
      end else begin
         for (int i = 0; i < COUNT; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
            timer_q[i] <= timer_d[i];
            last_q[i]  <= last_d[i];
         end
         ovf        <= ovf_d;
         stat_count <= stat_d;
      end
   end

endmodule

// File: tb/tb_int_coalescer.sv
module tb_int_coalescer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [4:0]  cfg_chan = '0;
   logic [7:0]  cfg_thresh = '0;
   logic [15:0] cfg_timeout = '0;
   logic [15:0] ev_pulse = '0;
   logic [15:0] int_valid;
   logic [15:0] int_ready = '0;
   logic [4:0]  stat_sel = '0;
   logic [7:0]  stat_count;
   logic [15:0] ovf;
   logic [15:0] ovf_clr = '0;

   int total = 0;
   int bad = 0;

   int_coalescer #(.COUNT(16), .CNT_W(8), .TMR_W(16)) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
      .cfg_thresh(cfg_thresh), .cfg_timeout(cfg_timeout),
      .ev_pulse(ev_pulse), .int_valid(int_valid), .int_ready(int_ready),
      .stat_sel(stat_sel), .stat_count(stat_count),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   // One clock edge; inputs change and outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [4:0] ch, input logic [7:0] th, input logic [15:0] to);
      cfg_valid = 1'b1; cfg_chan = ch; cfg_thresh = th; cfg_timeout = to;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL rst_int_valid got=%h exp=%h", int_valid, 16'h0000); end
      total++; if (ovf !== 16'h0000) begin bad++; $display("FAIL rst_ovf got=%h exp=%h", ovf, 16'h0000); end
      total++; if (stat_count !== 8'd0) begin bad++; $display("FAIL rst_stat got=%0d exp=%0d", stat_count, 0); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_ready got=%b exp=%b", cfg_ready, 1'b1); end
   endtask

   task automatic test_default_fire();
      ev_pulse = 16'h0008;
      tick();
      ev_pulse = '0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL dflt_accum got=%h exp=%h", int_valid, 16'h0000); end
      tick();
      total++; if (int_valid !== 16'h0008) begin bad++; $display("FAIL dflt_rise got=%h exp=%h", int_valid, 16'h0008); end
      tick(); tick();
      total++; if (int_valid !== 16'h0008) begin bad++; $display("FAIL dflt_hold got=%h exp=%h", int_valid, 16'h0008); end
      int_ready = 16'h0008; stat_sel = 5'd3;
      tick();
      int_ready = '0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL dflt_ack got=%h exp=%h", int_valid, 16'h0000); end
      tick();
      total++; if (stat_count !== 8'd1) begin bad++; $display("FAIL dflt_stat got=%0d exp=%0d", stat_count, 1); end
   endtask

   task automatic test_threshold();
      cfg(5'd0, 8'd4, 16'd0);
      for (int i = 0; i < 3; i++) begin
         ev_pulse = 16'h0001;
         tick();
      end
      ev_pulse = '0;
      // Readiness outside FIRE must not disturb the batch
      int_ready = 16'h0001;
      tick();
      int_ready = '0;
      for (int i = 0; i < 30; i++) tick();
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL thr_below got=%h exp=%h", int_valid, 16'h0000); end
      ev_pulse = 16'h0001;
      tick();
      ev_pulse = '0;
      total++; if (int_valid !== 16'h0001) begin bad++; $display("FAIL thr_reach got=%h exp=%h", int_valid, 16'h0001); end
      int_ready = 16'h0001; stat_sel = 5'd0;
      tick();
      int_ready = '0;
      tick();
      total++; if (stat_count !== 8'd4) begin bad++; $display("FAIL thr_stat got=%0d exp=%0d", stat_count, 4); end
      stat_sel = 5'd16;
      tick();
      total++; if (stat_count !== 8'd0) begin bad++; $display("FAIL stat_oor got=%0d exp=%0d", stat_count, 0); end
   endtask

   task automatic test_timeout();
      cfg(5'd1, 8'd100, 16'd20);
      ev_pulse = 16'h0002;
      tick();
      ev_pulse = '0;
      for (int i = 0; i < 19; i++) tick();
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL tmo_early got=%h exp=%h", int_valid, 16'h0000); end
      tick();
      total++; if (int_valid !== 16'h0002) begin bad++; $display("FAIL tmo_rise got=%h exp=%h", int_valid, 16'h0002); end
      for (int i = 0; i < 5; i++) begin
         ev_pulse = 16'h0002;
         tick();
      end
      ev_pulse = '0;
      int_ready = 16'h0002; stat_sel = 5'd1;
      tick();
      int_ready = '0;
      tick();
      total++; if (stat_count !== 8'd6) begin bad++; $display("FAIL tmo_stat got=%0d exp=%0d", stat_count, 6); end
   endtask

   task automatic test_back_to_back();
      ev_pulse = 16'h0004;
      tick();
      ev_pulse = '0;
      tick();
      total++; if (int_valid !== 16'h0004) begin bad++; $display("FAIL b2b_first got=%h exp=%h", int_valid, 16'h0004); end
      ev_pulse = 16'h0004; int_ready = 16'h0004; stat_sel = 5'd2;
      tick();
      ev_pulse = '0; int_ready = '0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL b2b_gap got=%h exp=%h", int_valid, 16'h0000); end
      tick();
      total++; if (int_valid !== 16'h0004) begin bad++; $display("FAIL b2b_refire got=%h exp=%h", int_valid, 16'h0004); end
      total++; if (stat_count !== 8'd2) begin bad++; $display("FAIL b2b_stat1 got=%0d exp=%0d", stat_count, 2); end
      int_ready = 16'h0004;
      tick();
      int_ready = '0;
      tick();
      total++; if (stat_count !== 8'd1) begin bad++; $display("FAIL b2b_stat2 got=%0d exp=%0d", stat_count, 1); end
   endtask

   task automatic test_saturation();
      cfg(5'd4, 8'd255, 16'd0);
      ev_pulse = 16'h0010;
      for (int i = 0; i < 300; i++) tick();
      ev_pulse = '0;
      total++; if (int_valid !== 16'h0010) begin bad++; $display("FAIL sat_fire got=%h exp=%h", int_valid, 16'h0010); end
      total++; if (ovf !== 16'h0010) begin bad++; $display("FAIL sat_ovf got=%h exp=%h", ovf, 16'h0010); end
      int_ready = 16'h0010; stat_sel = 5'd4;
      tick();
      int_ready = '0;
      tick();
      total++; if (stat_count !== 8'd255) begin bad++; $display("FAIL sat_stat got=%0d exp=%0d", stat_count, 255); end
      total++; if (ovf !== 16'h0010) begin bad++; $display("FAIL sat_sticky got=%h exp=%h", ovf, 16'h0010); end
      ovf_clr = 16'h0010;
      tick();
      ovf_clr = '0;
      total++; if (ovf !== 16'h0000) begin bad++; $display("FAIL sat_clr got=%h exp=%h", ovf, 16'h0000); end
   endtask

   task automatic test_reset_mid();
      cfg(5'd5, 8'd20, 16'd0);
      ev_pulse = 16'h0020;
      for (int i = 0; i < 7; i++) tick();
      ev_pulse = '0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL mid_accum got=%h exp=%h", int_valid, 16'h0000); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL mid_rst_valid got=%h exp=%h", int_valid, 16'h0000); end
      tick();
      total++; if (stat_count !== 8'd0) begin bad++; $display("FAIL mid_rst_stat got=%0d exp=%0d", stat_count, 0); end
      ev_pulse = 16'h0020;
      tick();
      ev_pulse = '0;
      tick();
      total++; if (int_valid !== 16'h0020) begin bad++; $display("FAIL mid_refire got=%h exp=%h", int_valid, 16'h0020); end
      // Out-of-range channel write must leave channel 0 at its default threshold
      cfg(5'd16, 8'd50, 16'd0);
      ev_pulse = 16'h0001;
      tick();
      ev_pulse = '0;
      tick();
      total++; if (int_valid !== 16'h0021) begin bad++; $display("FAIL cfg_oor got=%h exp=%h", int_valid, 16'h0021); end
      int_ready = 16'hffff;
      tick();
      int_ready = '0;
      total++; if (int_valid !== 16'h0000) begin bad++; $display("FAIL all_ack got=%h exp=%h", int_valid, 16'h0000); end
   endtask

   initial begin
      test_reset();
      test_default_fire();
      test_threshold();
      test_timeout();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
